can_frame_sequencer: RTL
========================

Name: can_frame_sequencer

Overview:
- Sequences the CAN size-detect datapath once per frame on the ch_unit receive path.
- Performs bus-idle integration and arms the size detector at SOF, then collects the DLC.
- Tracks the rest of the frame (payload, CRC, tail), skipping stuff bits, to find end-of-frame.
- Resets and re-arms the size detector between frames, and reports frame completion, stuff errors and header timeouts.

Parameters:
- IDLE_BITS, 11: consecutive recessive bits required before SOF is accepted.
- TIMEOUT_BITS, 64: bits allowed in header before sdComplete; exceeding this is a timeout.
- SD_RST_CYCLES, 2: clock cycles sdResetN is held low per recovery.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  global run; low parks the block
- dIn  in  1  voted bus bit (1 = recessive)
- bitValid  in  1  one-cycle pulse per voted bit; pulses at least 8 cycles apart
- sdEnable  out  1  enable to size detector
- sdResetN  out  1  active-low synchronous reset to size detector
- sdComplete  in  1  size detector done (level)
- sdMsgSize  in  4  DLC from size detector
- frameActive  out  1  high from SOF until frame end or abort
- frameDone  out  1  one-cycle pulse at end of tail
- dataLen  out  4  latched payload bytes, min(DLC,8)
- errStuff  out  1  one-cycle pulse on 6 equal consecutive stuffed-region bits
- errTimeout  out  1  one-cycle pulse on header timeout
- seqState  out  3  state encoding, for debug

Behaviour:
- Reset values: sdEnable=0, sdResetN=0, frameActive=0, frameDone=0, dataLen=0, errStuff=0, errTimeout=0, state=s_recover with rstCnt=0.
- States: s_recover, s_halt, s_idleSync, s_waitSof, s_header, s_payload, s_tail.
- s_recover:
  - sdResetN=0 for SD_RST_CYCLES cycles.
  - Then goes to s_idleSync if enable=1, else s_halt.
  - Clears idleCnt, runCnt, bitCnt.
- s_halt: sdResetN=1, all outputs idle; goes to s_idleSync when enable=1.
- s_idleSync:
  - On bitValid: dIn=1 increments idleCnt; dIn=0 clears it.
  - When idleCnt reaches IDLE_BITS, go to s_waitSof.
- s_waitSof:
  - sdEnable=1, so the size detector leaves hold and samples every bit.
  - On bitValid with dIn=0 (SOF): frameActive=1, runCnt=1, lastBit=0, bitCnt=0; go to s_header.
- Stuff tracking, active in s_header and s_payload on every bitValid:
  - If runCnt==5, the bit is a stuff bit. It must differ from lastBit: set runCnt=1, lastBit=dIn, and do not count it. If it equals lastBit, pulse errStuff and go to s_recover.
  - Otherwise, if dIn==lastBit then runCnt+1, else runCnt=1. Set lastBit=dIn.
- s_header:
  - sdEnable=1.
  - bitCnt counts every bitValid; bitCnt==TIMEOUT_BITS with sdComplete=0 pulses errTimeout and goes to s_recover.
  - On sdComplete=1: latch dataLen=(sdMsgSize>8)?8:sdMsgSize; load payCnt=dataLen*8+15 (7-bit, max 79); go to s_payload.
  - If bitValid coincides with sdComplete, the bit is processed as the first s_payload bit.
- s_payload:
  - sdEnable=0.
  - Each non-stuff bitValid decrements payCnt.
  - A decrement to 0 loads tailCnt=10 and goes to s_tail.
  - A stuff bit after the final CRC bit is still consumed here before the tail is counted. The first bit after payCnt=0 with runCnt==5 is treated as a stuff bit.
- s_tail:
  - No stuff tracking.
  - Each bitValid decrements tailCnt; 10 bits = CRC delimiter, ACK slot, ACK delimiter, 7 EOF bits.
  - At 0: frameDone pulse, frameActive=0, go to s_recover.
  - Bit values are not checked.
- enable=0 in any state other than s_recover/s_halt: next cycle go to s_recover, frameActive=0, no frameDone.
- Reset asserted mid-frame: immediate return to reset values; no pulses emitted.
- Pulse timing: error and done pulses are registered, asserted exactly one cycle, in the cycle the transition to s_recover is taken.
- seqState encoding: s_recover=0, s_halt=1, s_idleSync=2, s_waitSof=3, s_header=4, s_payload=5, s_tail=6.

Test Plan:
- Idle integration: 10 recessive bits then 0 -> remains s_idleSync, no frameActive. Then 11×1 and a 0 -> frameActive=1 at the SOF bitValid.
- Full frame, DLC=2, no stuffing: sdComplete with sdMsgSize=2 -> dataLen=2, payCnt=31. After 31 payload bits plus 10 tail bits, frameDone pulses once, followed by sdResetN low 2 cycles.
- Stuffing: payload containing 00000 followed by stuff bit 1 -> stuff bit not counted; frameDone arrives one bitValid later than the unstuffed case.
- Stuff error: 000000 in payload -> errStuff pulse, s_recover, no frameDone.
- DLC clamp and timeout: sdMsgSize=13 -> dataLen=8, payCnt=79. Separately, a header with no sdComplete for 64 bits -> errTimeout pulse.
- Abort: enable dropped mid-payload -> s_recover then s_halt, frameActive=0. Async reset mid-header -> all outputs reset immediately, sdResetN=0.

Source files
------------

// File: rtl/can_frame_sequencer.sv
// Per-frame sequencer for the CAN size-detect path: integrates bus idle, arms the
// size detector at SOF, tracks the stuffed payload/CRC and the tail, then re-arms.
module can_frame_sequencer #(
  parameter int IDLE_BITS     = 11,
  parameter int TIMEOUT_BITS  = 64,
  parameter int SD_RST_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       dIn_i,
  input  logic       bitValid_i,
  output logic       sdEnable_o,
  output logic       sdResetN_o,
  input  logic       sdComplete_i,
  input  logic [3:0] sdMsgSize_i,
  output logic       frameActive_o,
  output logic       frameDone_o,
  output logic [3:0] dataLen_o,
  output logic       errStuff_o,
  output logic       errTimeout_o,
  output logic [2:0] seqState_o
);

  // state       | meaning
  // S_RECOVER   | size detector held in reset for SD_RST_CYCLES, counters cleared
  // S_HALT      | parked while enable is low
  // S_IDLE_SYNC | counting consecutive recessive bits
  // S_WAIT_SOF  | bus idle seen, waiting for the dominant SOF bit
  // S_HEADER    | size detector sampling, waiting for sdComplete
  // S_PAYLOAD   | counting data + CRC bits, skipping stuff bits
  // S_TAIL      | CRC delimiter, ACK, EOF (unstuffed)
  typedef enum logic [2:0] {
    S_RECOVER   = 3'd0,
    S_HALT      = 3'd1,
    S_IDLE_SYNC = 3'd2,
    S_WAIT_SOF  = 3'd3,
    S_HEADER    = 3'd4,
    S_PAYLOAD   = 3'd5,
    S_TAIL      = 3'd6
  } state_e;

  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  localparam int RW = $clog2(SD_RST_CYCLES + 1);

  state_e        state_q, state_d;
  logic [RW-1:0] rstCnt_q, rstCnt_d;
  logic [IW-1:0] idleCnt_q, idleCnt_d;
  logic [2:0]    runCnt_q, runCnt_d;
  logic          lastBit_q, lastBit_d;
  logic [TW-1:0] bitCnt_q, bitCnt_d;
  logic [6:0]    payCnt_q, payCnt_d;
  logic [3:0]    tailCnt_q, tailCnt_d;
  logic [3:0]    dataLen_q, dataLen_d;
  logic          frameActive_q, frameActive_d;
  logic          frameDone_q, frameDone_d;
  logic          errStuff_q, errStuff_d;
  logic          errTimeout_q, errTimeout_d;

  logic       is_stuff, stuff_err;
  logic [2:0] run_nxt;
  logic [3:0] clamp_len;
  logic [6:0] pay_load;

  assign is_stuff  = (runCnt_q == 3'd5);
  assign stuff_err = is_stuff && (dIn_i == lastBit_q);
  assign run_nxt   = (!is_stuff && dIn_i == lastBit_q) ? runCnt_q + 3'd1 : 3'd1;
  assign clamp_len = (sdMsgSize_i > 4'd8) ? 4'd8 : sdMsgSize_i;
  assign pay_load  = {clamp_len, 3'b000} + 7'd15;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_RECOVER;
      rstCnt_q      <= '0;
      idleCnt_q     <= '0;
      runCnt_q      <= '0;
      lastBit_q     <= 1'b0;
      bitCnt_q      <= '0;
      payCnt_q      <= '0;
      tailCnt_q     <= '0;
      dataLen_q     <= '0;
      frameActive_q <= 1'b0;
      frameDone_q   <= 1'b0;
      errStuff_q    <= 1'b0;
      errTimeout_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rstCnt_q      <= rstCnt_d;
      idleCnt_q     <= idleCnt_d;
      runCnt_q      <= runCnt_d;
      lastBit_q     <= lastBit_d;
      bitCnt_q      <= bitCnt_d;
      payCnt_q      <= payCnt_d;
      tailCnt_q     <= tailCnt_d;
      dataLen_q     <= dataLen_d;
      frameActive_q <= frameActive_d;
      frameDone_q   <= frameDone_d;
      errStuff_q    <= errStuff_d;
      errTimeout_q  <= errTimeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rstCnt_d      = rstCnt_q;
    idleCnt_d     = idleCnt_q;
    runCnt_d      = runCnt_q;
    lastBit_d     = lastBit_q;
    bitCnt_d      = bitCnt_q;
    payCnt_d      = payCnt_q;
    tailCnt_d     = tailCnt_q;
    dataLen_d     = dataLen_q;
    frameActive_d = frameActive_q;
    frameDone_d   = 1'b0;
    errStuff_d    = 1'b0;
    errTimeout_d  = 1'b0;

    if (!enable_i && state_q != S_RECOVER && state_q != S_HALT) begin
      state_d       = S_RECOVER;
      rstCnt_d      = '0;
      frameActive_d = 1'b0;
    end else begin
      unique case (state_q)
        S_RECOVER: begin
          idleCnt_d     = '0;
          runCnt_d      = '0;
          bitCnt_d      = '0;
          frameActive_d = 1'b0;
          if (rstCnt_q == RW'(SD_RST_CYCLES - 1)) begin
            rstCnt_d = '0;
            state_d  = enable_i ? S_IDLE_SYNC : S_HALT;
          end else begin
            rstCnt_d = rstCnt_q + 1'b1;
          end
        end
        S_HALT: begin
          if (enable_i) state_d = S_IDLE_SYNC;
        end
        S_IDLE_SYNC: begin
          if (bitValid_i) begin
            if (!dIn_i) begin
              idleCnt_d = '0;
            end else if (idleCnt_q == IW'(IDLE_BITS - 1)) begin
              idleCnt_d = '0;
              state_d   = S_WAIT_SOF;
            end else begin
              idleCnt_d = idleCnt_q + 1'b1;
            end
          end
        end
        S_WAIT_SOF: begin
          if (bitValid_i && !dIn_i) begin
            frameActive_d = 1'b1;
            runCnt_d      = 3'd1;
            lastBit_d     = 1'b0;
            bitCnt_d      = '0;
            state_d       = S_HEADER;
          end
        end
        S_HEADER: begin
          if (sdComplete_i) begin
            // a coincident bit is already the first payload bit
            dataLen_d = clamp_len;
            payCnt_d  = pay_load;
            state_d   = S_PAYLOAD;
            if (bitValid_i) begin
              if (stuff_err) begin
                errStuff_d    = 1'b1;
                frameActive_d = 1'b0;
                rstCnt_d      = '0;
                state_d       = S_RECOVER;
              end else begin
                runCnt_d  = run_nxt;
                lastBit_d = dIn_i;
                if (!is_stuff) payCnt_d = pay_load - 7'd1;
              end
            end
          end else if (bitCnt_q == TW'(TIMEOUT_BITS)) begin
            errTimeout_d  = 1'b1;
            frameActive_d = 1'b0;
            rstCnt_d      = '0;
            state_d       = S_RECOVER;
          end else if (bitValid_i) begin
            bitCnt_d = bitCnt_q + 1'b1;
            if (stuff_err) begin
              errStuff_d    = 1'b1;
              frameActive_d = 1'b0;
              rstCnt_d      = '0;
              state_d       = S_RECOVER;
            end else begin
              runCnt_d  = run_nxt;
              lastBit_d = dIn_i;
            end
          end
        end
        S_PAYLOAD: begin
          if (bitValid_i) begin
            if (stuff_err) begin
              errStuff_d    = 1'b1;
              frameActive_d = 1'b0;
              rstCnt_d      = '0;
              state_d       = S_RECOVER;
            end else begin
              runCnt_d  = run_nxt;
              lastBit_d = dIn_i;
              if (is_stuff) begin
                if (payCnt_q == 7'd0) begin
                  tailCnt_d = 4'd10;
                  state_d   = S_TAIL;
                end
              end else begin
                payCnt_d = payCnt_q - 7'd1;
                // hold at zero when the last CRC bit still owes a stuff bit
                if (payCnt_q == 7'd1 && run_nxt != 3'd5) begin
                  tailCnt_d = 4'd10;
                  state_d   = S_TAIL;
                end
              end
            end
          end
        end
        S_TAIL: begin
          if (bitValid_i) begin
            if (tailCnt_q == 4'd1) begin
              tailCnt_d     = '0;
              frameDone_d   = 1'b1;
              frameActive_d = 1'b0;
              rstCnt_d      = '0;
              state_d       = S_RECOVER;
            end else begin
              tailCnt_d = tailCnt_q - 4'd1;
            end
          end
        end
        default: begin
          rstCnt_d = '0;
          state_d  = S_RECOVER;
        end
      endcase
    end
  end

  always_comb begin
    sdEnable_o = (state_q == S_WAIT_SOF) || (state_q == S_HEADER);
    sdResetN_o = (state_q != S_RECOVER);
  end

  assign frameActive_o = frameActive_q;
  assign frameDone_o   = frameDone_q;
  assign dataLen_o     = dataLen_q;
  assign errStuff_o    = errStuff_q;
  assign errTimeout_o  = errTimeout_q;
  assign seqState_o    = state_q;

endmodule
